// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and destination tag passed through.
module muldiv_unit #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             flush,
   input  logic [2:0]       funct3,
   input  logic [XLEN-1:0]  op_a,
   input  logic [XLEN-1:0]  op_b,
   input  logic [TAG_W-1:0] tag_in,
   output logic             busy,
   output logic             done,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] tag_out
);

   localparam int unsigned CntW = $clog2(XLEN);

   typedef enum logic [1:0] {StIdle, StCalc, StAdj, StDone} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   addend_q, addend_d;
   logic [2:0]        op_q, op_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              neg_q, neg_d;
   logic              rneg_q, rneg_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [TAG_W-1:0]  tag_out_q, tag_out_d;

   logic            a_signed, b_signed, sa, sb, is_div, div_zero, div_ovf, accept;
   logic [XLEN-1:0] mag_a, mag_b;

   always_comb begin
      a_signed = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
      b_signed = funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
      sa       = a_signed & op_a[XLEN-1];
      sb       = b_signed & op_b[XLEN-1];
      mag_a    = sa ? -op_a : op_a;
      mag_b    = sb ? -op_b : op_b;
      is_div   = funct3[2];
      div_zero = is_div && (op_b == '0);
      div_ovf  = is_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
      accept   = start && !flush && (state_q == StIdle || state_q == StDone);
   end

   // Datapath step: multiply keeps {partial product, multiplier}, divide keeps
   // {partial remainder, dividend/quotient} in the same accumulator.
   logic [XLEN:0]   mul_sum, mul_hi, rem_shift, rem_diff;
   logic [2*XLEN-1:0] step_acc;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, addend_q};
      mul_hi    = acc_q[0] ? mul_sum : {1'b0, acc_q[2*XLEN-1:XLEN]};
      rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      rem_diff  = rem_shift - {1'b0, addend_q};
      if (!op_q[2]) begin
         step_acc = {mul_hi, acc_q[XLEN-1:1]};
      end else if (!rem_diff[XLEN]) begin
         step_acc = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
         step_acc = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
   end

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, adj_res;

   always_comb begin
      prod_fix = neg_q ? -acc_q : acc_q;
      quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_fix  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      case (op_q)
         3'b000:                 adj_res = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: adj_res = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         adj_res = quo_fix;
         default:                adj_res = rem_fix;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      addend_d  = addend_q;
      op_d      = op_q;
      tag_d     = tag_q;
      neg_d     = neg_q;
      rneg_d    = rneg_q;
      result_d  = result_q;
      tag_out_d = tag_out_q;

      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (accept) begin
               op_d  = funct3;
               tag_d = tag_in;
               cnt_d = '0;
               if (div_zero || div_ovf) begin
                  // Final values are loaded directly; no sign fix-up applies.
                  state_d  = StAdj;
                  acc_d    = div_zero ? {op_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, op_a};
                  addend_d = op_b;
                  neg_d    = 1'b0;
                  rneg_d   = 1'b0;
               end else begin
                  state_d  = StCalc;
                  acc_d    = is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
                  addend_d = is_div ? mag_b : mag_a;
                  neg_d    = sa ^ sb;
                  rneg_d   = sa;
               end
            end
         end
         StCalc: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               acc_d = step_acc;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntW'(XLEN - 1)) begin
                  state_d = StAdj;
               end
            end
         end
         StAdj: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               state_d   = StDone;
               result_d  = adj_res;
               tag_out_d = tag_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         acc_q     <= '0;
         addend_q  <= '0;
         op_q      <= '0;
         tag_q     <= '0;
         neg_q     <= 1'b0;
         rneg_q    <= 1'b0;
         result_q  <= '0;
         tag_out_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         addend_q  <= addend_d;
         op_q      <= op_d;
         tag_q     <= tag_d;
         neg_q     <= neg_d;
         rneg_q    <= rneg_d;
         result_q  <= result_d;
         tag_out_q <= tag_out_d;
      end
   end

   assign busy    = (state_q == StCalc) || (state_q == StAdj);
   assign done    = (state_q == StDone);
   assign result  = result_q;
   assign tag_out = tag_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases with literal expectations, then
// random traffic checked every cycle against an arithmetic reference model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b;
   logic [4:0]  tag_in;
   logic        busy, done;
   logic [31:0] result;
   logic [4:0]  tag_out;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
      .op_a(op_a), .op_b(op_b), .tag_in(tag_in), .busy(busy), .done(done),
      .result(result), .tag_out(tag_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // RV32M semantics from plain 64-bit arithmetic.
   function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, p;
      longint unsigned ua, ub, pu;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * $signed(ub); return p[63:32]; end
         3'd3: begin pu = ua * ub; return pu[63:32]; end
         3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
         3'd5: begin if (b == 0) return 32'hFFFF_FFFF; pu = ua / ub; return pu[31:0]; end
         3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
         default: begin if (b == 0) return a; pu = ua % ub; return pu[31:0]; end
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
      return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   // Reference model: busy for (latency-1) cycles after acceptance, then done.
   logic        m_busy, m_done;
   int          m_left;
   logic [31:0] m_result, p_res;
   logic [4:0]  m_tag, p_tag;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0; m_result <= '0; m_tag <= '0;
      end else if (m_busy) begin
         if (flush) begin
            m_busy <= 1'b0; m_done <= 1'b0;
         end else if (m_left == 1) begin
            m_busy <= 1'b0; m_done <= 1'b1; m_result <= p_res; m_tag <= p_tag;
         end else begin
            m_left <= m_left - 1;
         end
      end else begin
         m_done <= 1'b0;
         if (start && !flush) begin
            m_busy <= 1'b1;
            m_left <= is_special(funct3, op_a, op_b) ? 1 : 33;
            p_res  <= ref_res(funct3, op_a, op_b);
            p_tag  <= tag_in;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc busy", busy, m_busy);
         check("cyc done", done, m_done);
         check("cyc result", result, m_result);
         check("cyc tag_out", tag_out, m_tag);
      end
   end

   // Called at a negedge; leaves the bench at the negedge of the done cycle.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input logic [31:0] exp, input int lat,
                         input string nm);
      int cyc;
      start = 1'b1; funct3 = f; op_a = a; op_b = b; tag_in = t;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check({nm, " latency"}, cyc, lat);
      check({nm, " result"}, result, exp);
      check({nm, " tag"}, tag_out, t);
   endtask

   initial begin
      int dcnt, cyc;
      rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0; tag_in = '0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset result", result, 32'h0);
      check("reset tag", tag_out, 5'h0);
      rst = 1'b0;
      @(negedge clk);

      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 34, "mul");
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 34, "mulh b2b");
      @(negedge clk);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, 34, "mulhu");
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, 34, "mulhsu");
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 34, "div");
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 34, "rem");
      run_op(3'd5, 32'd100, 32'd7, 5'd9, 32'd14, 34, "divu");
      run_op(3'd7, 32'd100, 32'd7, 5'd10, 32'd2, 34, "remu");
      run_op(3'd4, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 2, "div0");
      run_op(3'd6, 32'd5, 32'd0, 5'd12, 32'd5, 2, "rem0");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 2, "div ovf");
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 2, "rem ovf");
      @(negedge clk);

      // Flush mid-CALC: no completion, result unchanged.
      start = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; tag_in = 5'd20;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush busy", busy, 1'b0);
      check("flush result", result, 32'd0);
      check("flush tag", tag_out, 5'd14);
      dcnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("flush no done", dcnt, 0);

      // Start while busy is ignored.
      start = 1'b1; funct3 = 3'd0; op_a = 32'd7; op_b = 32'hFFFF_FFFD; tag_in = 5'd9;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 100) begin
         if (cyc == 5) begin
            start = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; tag_in = 5'd1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check("ignore latency", cyc, 34);
      check("ignore result", result, 32'hFFFF_FFEB);
      check("ignore tag", tag_out, 5'd9);
      @(negedge clk);

      // start and flush together: nothing accepted.
      start = 1'b1; flush = 1'b1; funct3 = 3'd4; op_a = 32'd5; op_b = 32'd0;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("start+flush busy", busy, 1'b0);
      @(negedge clk);
      check("start+flush done", done, 1'b0);

      // Reset during a multiply.
      start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5; tag_in = 5'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst busy", busy, 1'b0);
      check("rst done", done, 1'b0);
      check("rst result", result, 32'h0);
      check("rst tag", tag_out, 5'h0);

      // Random traffic; the per-cycle compare process does the checking.
      for (int i = 0; i < 8000; i++) begin
         int ra, rb;
         ra = $urandom_range(0, 7);
         rb = $urandom_range(0, 7);
         start  = ($urandom_range(0, 7) == 0);
         flush  = ($urandom_range(0, 99) == 0);
         rst    = ($urandom_range(0, 1999) == 0);
         funct3 = 3'($urandom);
         tag_in = 5'($urandom);
         op_a   = (ra == 0) ? 32'h8000_0000 : (ra == 1) ? 32'($urandom_range(0, 300)) : $urandom;
         op_b   = (rb == 0) ? 32'h0 : (rb == 1) ? 32'hFFFF_FFFF :
                  (rb == 2) ? 32'($urandom_range(1, 20)) : $urandom;
         @(negedge clk);
      end
      start = 1'b0; flush = 1'b0; rst = 1'b0;
      repeat (40) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit adding the RV32M operations to the 5-stage pipelined core.
- Sits in the execute stage beside the ALU. It accepts one operation per start pulse, computes one bit per cycle, and returns the result with a destination tag.
- The pipeline stalls while busy=1. A branch redirect or trap kills the in-flight operation via flush.
- Width and tag size are parametrised.

Parameters:
- XLEN, 32, operand/result width (≥4, even).
- TAG_W, 5, width of destination-register tag carried through.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when idle or in DONE.
- flush  in  1  synchronous kill of any in-flight op.
- funct3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value.
- op_b  in  XLEN  rs2 value.
- tag_in  in  TAG_W  destination register of the request.
- busy  out  1  high in CALC and ADJ.
- done  out  1  one-cycle completion strobe.
- result  out  XLEN  result, held until next completion.
- tag_out  out  TAG_W  tag of the completed op, held with result.

Behaviour:

Reset and states:
- Reset (synchronous, active-high; clk single clock) forces state IDLE, busy=0, done=0, result=0, tag_out=0. It overrides start/flush and aborts any in-flight op.
- States: IDLE, CALC, ADJ, DONE. done=1 only in DONE. busy=1 only in CALC/ADJ.

Accepting a request:
- start is accepted in IDLE or DONE, which allows back-to-back ops. On acceptance, the unit latches funct3, tag_in, and the operand magnitudes/signs.
- start in CALC/ADJ is ignored and the request is not queued.

Signedness:
- MUL/MULH/DIV/REM: both operands are signed.
- MULHSU: op_a is signed, op_b is unsigned.
- MULHU/DIVU/REMU: both operands are unsigned.
- Signed operands are converted to magnitude. The result sign is recorded: product sign = sa^sb, quotient sign = sa^sb, remainder sign = sa.

Normal path:
- IDLE/DONE → CALC on accepted start.
- CALC runs exactly XLEN cycles (counter 0..XLEN-1).
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring, one quotient bit per cycle.
- CALC → ADJ: negate the 2·XLEN product / quotient / remainder when its sign flag is set. Then select:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- ADJ → DONE: result/tag_out are registered.
- DONE → IDLE if no start, else → CALC (or ADJ for a special case).

Special cases (skip CALC, go straight to ADJ):
- Divide by zero (op_b=0):
  - DIV/DIVU: quotient = all ones.
  - REM/REMU: remainder = op_a.
- Signed overflow (DIV/REM, op_a = 100…0, op_b = all ones): quotient = op_a, remainder = 0.

Latency:
- Start sampled at edge 0. Normal ops assert done in cycle XLEN+2 (34 for XLEN=32).
- Special cases assert done in cycle 2.

Flush:
- In CALC/ADJ: next state IDLE, busy drops next cycle, done is never asserted, result/tag_out keep prior values.
- In DONE: done still completes that cycle. A start in the same cycle is dropped.
- start and flush in the same cycle: flush wins, no op accepted.

Outputs:
- result/tag_out change only on entry to DONE (or reset).

Test Plan:
- Reset, then MUL op_a=7, op_b=0xFFFFFFFD → busy cycles 1..33, done=1 cycle 34, result=0xFFFFFFEB, tag_out=tag_in.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, both done at cycle 2; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0, done at cycle 2.
- Start DIVU, flush at cycle 10 → busy=0 at cycle 11, no done, result unchanged. Start during busy ignored. start+flush same cycle → stays IDLE.
- rst at cycle 15 of a MUL → next cycle busy=0, done=0, result=0. Back-to-back start asserted in DONE → second result done exactly 34 cycles later.
